// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared types and constants for the memory request arbiter
//
// Contents:
//   arb_state_t   : arbiter FSM states (IDLE, WAIT, RELEASE)
//   ARB_NUM_REQ   : number of requesters sharing the memory interface unit
//   ARB_RDATA_ERR : read data returned on a watchdog-forced completion
package tinyalu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam int         ARB_NUM_REQ   = 2;
    localparam logic [7:0] ARB_RDATA_ERR = 8'hFF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - WAIT-state cycle counter that flags a hung memory
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart the count from zero (held while not waiting)
//   enable       : count one cycle per rising edge
//   expired      : high during the TIMEOUT-th enabled cycle; never high if TIMEOUT=0
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count runs 0..TIMEOUT-1, so TIMEOUT values need only clog2(TIMEOUT) bits.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expired = (TIMEOUT != 0) && enable && (cnt_q == CNT_W'(TIMEOUT - 1));
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin arbiter sharing one memory interface unit between two requesters
//
// Ports:
//   clk, reset_n                     : clock, asynchronous active-low reset
//   load/store/addr/wdata 0,1        : level-held requests from each instruction unit
//   done0/1, rdata0/1                : one-cycle completion pulse and read data per requester
//   m_load, m_store, m_addr, m_wdata : request forwarded to the memory interface unit
//   m_done, m_rdata                  : completion and read data from the memory interface unit
//   grant                            : one-hot owner of the current transaction
//   busy                             : high in WAIT and RELEASE
//   timeout_err, proto_err           : sticky error flags, cleared by clear_err
module mem_req_arbiter
    import tinyalu_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load0,
    input  logic                   store0,
    input  logic [ADDR_W-1:0]      addr0,
    input  logic [RES_W-1:0]       wdata0,
    output logic                   done0,
    output logic [DATA_W-1:0]      rdata0,
    input  logic                   load1,
    input  logic                   store1,
    input  logic [ADDR_W-1:0]      addr1,
    input  logic [RES_W-1:0]       wdata1,
    output logic                   done1,
    output logic [DATA_W-1:0]      rdata1,
    output logic                   m_load,
    output logic                   m_store,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [RES_W-1:0]       m_wdata,
    input  logic                   m_done,
    input  logic [DATA_W-1:0]      m_rdata,
    output logic [ARB_NUM_REQ-1:0] grant,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   proto_err,
    input  logic                   clear_err
);

    localparam logic [DATA_W-1:0] RDATA_ERR =
        (DATA_W <= 8) ? DATA_W'(ARB_RDATA_ERR) : {DATA_W{1'b1}};

    arb_state_t               state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic [ARB_NUM_REQ-1:0]   grant_q, grant_d;
    logic                     busy_q, busy_d;
    logic                     m_load_q, m_load_d, m_store_q, m_store_d;
    logic [ADDR_W-1:0]        m_addr_q, m_addr_d;
    logic [RES_W-1:0]         m_wdata_q, m_wdata_d;
    logic                     done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                     timeout_err_q, timeout_err_d;
    logic                     proto_err_q, proto_err_d;

    logic act0, act1, win, win_load, win_store, finish;
    logic wd_expired, new_proto, new_timeout;
    logic [DATA_W-1:0] ret_data;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != ARB_WAIT),
        .enable  (state_q == ARB_WAIT),
        .expired (wd_expired)
    );

    always_comb begin
        act0      = load0 | store0;
        act1      = load1 | store1;
        // On a tie the requester that did not win last time goes next.
        win       = (act0 && act1) ? ~last_grant_q : act1;
        win_load  = win ? load1  : load0;
        win_store = win ? store1 : store0;
        // m_done takes priority over a watchdog expiry in the same cycle.
        finish    = m_done | wd_expired;
        ret_data  = m_done ? m_rdata : RDATA_ERR;

        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        m_load_d      = m_load_q;
        m_store_d     = m_store_q;
        m_addr_d      = m_addr_q;
        m_wdata_d     = m_wdata_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        new_proto     = 1'b0;
        new_timeout   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                new_proto = m_done;
                if (act0 || act1) begin
                    state_d      = ARB_WAIT;
                    last_grant_d = win;
                    grant_d      = win ? 2'b10 : 2'b01;
                    m_addr_d     = win ? addr1 : addr0;
                    m_wdata_d    = win ? wdata1 : wdata0;
                    // Load and store together is illegal; service it as a load.
                    m_load_d     = win_load;
                    m_store_d    = win_store & ~win_load;
                    new_proto    = new_proto | (win_load & win_store);
                end
            end
            ARB_WAIT: begin
                if (finish) begin
                    state_d     = ARB_RELEASE;
                    m_load_d    = 1'b0;
                    m_store_d   = 1'b0;
                    new_timeout = ~m_done;
                    if (grant_q[1]) begin
                        done1_d  = 1'b1;
                        rdata1_d = ret_data;
                    end else begin
                        done0_d  = 1'b1;
                        rdata0_d = ret_data;
                    end
                end
            end
            ARB_RELEASE: begin
                // Dead cycle lets the finished requester drop its stale request.
                new_proto = m_done;
                state_d   = ARB_IDLE;
                grant_d   = '0;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d        = (state_d != ARB_IDLE);
        timeout_err_d = (timeout_err_q & ~clear_err) | new_timeout;
        proto_err_d   = (proto_err_q & ~clear_err) | new_proto;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            m_load_q      <= 1'b0;
            m_store_q     <= 1'b0;
            m_addr_q      <= '0;
            m_wdata_q     <= '0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            m_load_q      <= m_load_d;
            m_store_q     <= m_store_d;
            m_addr_q      <= m_addr_d;
            m_wdata_q     <= m_wdata_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign m_load      = m_load_q;
    assign m_store     = m_store_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              load0 = 0, store0 = 0, load1 = 0, store1 = 0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [RES_W-1:0]  wdata0 = '0, wdata1 = '0;
    logic              done0, done1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              m_load, m_store;
    logic [ADDR_W-1:0] m_addr;
    logic [RES_W-1:0]  m_wdata;
    logic              m_done = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic [1:0]        grant;
    logic              busy, timeout_err, proto_err;
    logic              clear_err = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int         exp_req[$];
    logic [7:0] exp_rd[$];

    mem_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .load0(load0), .store0(store0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .rdata0(rdata0),
        .load1(load1), .store1(store1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .rdata1(rdata1),
        .m_load(m_load), .m_store(m_store), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_rdata(m_rdata),
        .grant(grant), .busy(busy),
        .timeout_err(timeout_err), .proto_err(proto_err), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until the memory side sees a request, bounded.
    task automatic wait_req(input int budget);
        int n = 0;
        while (!(m_load || m_store) && n < budget) begin
            tick();
            n++;
        end
        chk("req_seen", m_load | m_store, 1);
    endtask

    // Compare the done pulse now visible against the oldest scoreboard entry.
    task automatic check_done();
        int         w;
        logic [7:0] d;
        chk("sb_nonempty", exp_req.size() != 0, 1);
        if (exp_req.size() != 0) begin
            w = exp_req.pop_front();
            d = exp_rd.pop_front();
            chk("done0", done0, w == 0);
            chk("done1", done1, w == 1);
            chk("rdata", (w == 1) ? rdata1 : rdata0, d);
        end
    endtask

    task automatic reply(input logic [7:0] rd, input int who);
        m_done  = 1'b1;
        m_rdata = rd;
        exp_req.push_back(who);
        exp_rd.push_back(rd);
        tick();
        m_done  = 1'b0;
        m_rdata = '0;
        check_done();
    endtask

    task automatic clear_errors();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [1:0] exp_g;

        // Reset state
        repeat (2) tick();
        chk("rst_m_load", m_load, 0);
        chk("rst_m_store", m_store, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_errs", {timeout_err, proto_err}, 0);
        reset_n = 1'b1;
        tick();

        // Single load from requester 0
        load0 = 1'b1; addr0 = 14'h010;
        tick();
        chk("ld_m_load", m_load, 1);
        chk("ld_m_store", m_store, 0);
        chk("ld_m_addr", m_addr, 14'h010);
        chk("ld_grant", grant, 2'b01);
        chk("ld_busy", busy, 1);
        reply(8'h5A, 0);
        chk("ld_m_load_off", m_load, 0);
        load0 = 1'b0;
        tick();
        chk("ld_grant_idle", grant, 0);
        chk("ld_busy_idle", busy, 0);
        chk("ld_done_off", done0, 0);
        chk("ld_rdata_hold", rdata0, 8'h5A);

        // Single store from requester 1
        store1 = 1'b1; addr1 = 14'h012; wdata1 = 16'h1234;
        tick();
        chk("st_m_store", m_store, 1);
        chk("st_m_load", m_load, 0);
        chk("st_m_addr", m_addr, 14'h012);
        chk("st_m_wdata", m_wdata, 16'h1234);
        chk("st_grant", grant, 2'b10);
        reply(8'h77, 1);
        store1 = 1'b0;
        tick();
        chk("st_grant_idle", grant, 0);

        // Contention from reset, memory latency 2
        reset_n = 1'b0;
        load0 = 1'b1; addr0 = 14'h100;
        load1 = 1'b1; addr1 = 14'h200;
        tick();
        reset_n = 1'b1;
        exp_g = 2'b01;
        for (int i = 0; i < 4; i++) begin
            wait_req(10);
            chk("cont_grant", grant, exp_g);
            chk("cont_addr", m_addr, (exp_g == 2'b01) ? 14'h100 : 14'h200);
            tick();
            reply(8'h40 + 8'(i), (exp_g == 2'b01) ? 0 : 1);
            exp_g = ~exp_g;
        end
        load0 = 1'b0; load1 = 1'b0;
        repeat (2) tick();

        // Watchdog timeout
        load0 = 1'b1; addr0 = 14'h020;
        wait_req(10);
        exp_req.push_back(0);
        exp_rd.push_back(8'hFF);
        cyc = 1;
        while (!(done0 || done1) && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("tmo_latency", cyc, TIMEOUT + 1);
        check_done();
        chk("tmo_err", timeout_err, 1);
        chk("tmo_proto", proto_err, 0);
        load0 = 1'b0;
        tick();
        clear_errors();
        chk("tmo_cleared", timeout_err, 0);

        // Load and store together
        load0 = 1'b1; store0 = 1'b1; addr0 = 14'h030;
        wait_req(10);
        chk("pe_m_load", m_load, 1);
        chk("pe_m_store", m_store, 0);
        chk("pe_err", proto_err, 1);
        reply(8'h11, 0);
        load0 = 1'b0; store0 = 1'b0;
        tick();
        clear_errors();
        chk("pe_cleared", proto_err, 0);

        // m_done while idle
        m_done = 1'b1; m_rdata = 8'h99;
        tick();
        m_done = 1'b0; m_rdata = '0;
        tick();
        chk("idle_done_none", {done0, done1}, 0);
        chk("idle_done_pe", proto_err, 1);
        chk("idle_grant", grant, 0);
        clear_errors();

        // Asynchronous reset while waiting
        load1 = 1'b1; addr1 = 14'h055;
        wait_req(10);
        chk("ar_grant_pre", grant, 2'b10);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_m_load", m_load, 0);
        chk("ar_grant", grant, 0);
        chk("ar_busy", busy, 0);
        @(negedge clk);
        load0 = 1'b1; addr0 = 14'h066;
        reset_n = 1'b1;
        wait_req(10);
        chk("ar_regrant", grant, 2'b01);
        reply(8'h3C, 0);
        load0 = 1'b0;
        wait_req(10);
        chk("ar_next", grant, 2'b10);
        reply(8'hC3, 1);
        load1 = 1'b0;
        tick();
        chk("ar_no_errs", {timeout_err, proto_err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
